// File: rtl/mem_ctrl_fc.sv
// Memory-side responder: serialises one SLB load/store or one instruction fetch
// at a time onto the byte-wide RAM port and returns 32-bit little-endian words.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | free to accept a request (SLB has priority over fetch)
//   LOAD    | SLB 4-byte read, one byte lane per cycle
//   FETCH   | fetch 4-byte read, one byte lane per cycle
//   STORE   | SLB store, one byte written per cycle
//   IO_WAIT | store to the IO port blocked while io_buffer_full is high
//   RESP    | holding load data until the SLB takes it
module mem_ctrl_fc #(
    parameter int                   AddrWidth = 32,
    parameter logic [AddrWidth-1:0] IoAddr    = 32'h30000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 is_exception,
    input  logic [AddrWidth-1:0] addr_from_slb,
    input  logic [31:0]          data_from_slb,
    input  logic [2:0]           len_from_slb,
    input  logic                 is_empty_from_slb,
    input  logic                 is_store_from_slb,
    input  logic                 is_receive_from_slb,
    output logic [31:0]          data_to_slb,
    output logic                 is_stall_to_slb,
    output logic                 is_finish_to_slb,
    output logic                 is_instr_to_slb,
    input  logic [AddrWidth-1:0] addr_from_if,
    input  logic                 is_req_from_if,
    output logic [31:0]          instr_to_if,
    output logic                 is_finish_to_if,
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [AddrWidth-1:0] mem_a,
    output logic                 mem_wr,
    input  logic                 io_buffer_full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_STORE,
        S_IO_WAIT,
        S_RESP
    } state_t;

    state_t               state;
    logic [AddrWidth-1:0] addr_q;
    logic [31:0]          data_q;
    logic [2:0]           len_q;
    logic [2:0]           cnt;
    logic [2:0]           cnt_nxt;
    logic [23:0]          word_q;

    // Anything other than 1 or 2 bytes is written as a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        case (len)
            3'd1:    norm_len = 3'd1;
            3'd2:    norm_len = 3'd2;
            default: norm_len = 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] store_byte(input logic [31:0] d, input logic [1:0] k);
        case (k)
            2'd0:    store_byte = d[7:0];
            2'd1:    store_byte = d[15:8];
            2'd2:    store_byte = d[23:16];
            default: store_byte = d[31:24];
        endcase
    endfunction

    always_comb begin
        cnt_nxt = cnt + 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            addr_q           <= '0;
            data_q           <= '0;
            len_q            <= '0;
            cnt              <= '0;
            word_q           <= '0;
            data_to_slb      <= '0;
            is_stall_to_slb  <= 1'b0;
            is_finish_to_slb <= 1'b0;
            is_instr_to_slb  <= 1'b0;
            instr_to_if      <= '0;
            is_finish_to_if  <= 1'b0;
            mem_dout         <= '0;
            mem_a            <= '0;
            mem_wr           <= 1'b0;
        end else begin
            is_finish_to_if <= 1'b0;
            case (state)
                S_IDLE: begin
                    is_finish_to_slb <= 1'b0;
                    is_instr_to_slb  <= 1'b0;
                    mem_wr           <= 1'b0;
                    if (!is_exception) begin
                        if (!is_empty_from_slb) begin
                            addr_q          <= addr_from_slb;
                            data_q          <= data_from_slb;
                            len_q           <= norm_len(len_from_slb);
                            cnt             <= '0;
                            mem_a           <= addr_from_slb;
                            is_stall_to_slb <= 1'b1;
                            if (is_store_from_slb) begin
                                if (addr_from_slb == IoAddr && io_buffer_full) begin
                                    state <= S_IO_WAIT;
                                end else begin
                                    state    <= S_STORE;
                                    mem_wr   <= 1'b1;
                                    mem_dout <= data_from_slb[7:0];
                                end
                            end else begin
                                state <= S_LOAD;
                            end
                        end else if (is_req_from_if) begin
                            addr_q          <= addr_from_if;
                            cnt             <= '0;
                            mem_a           <= addr_from_if;
                            is_stall_to_slb <= 1'b1;
                            state           <= S_FETCH;
                        end
                    end
                end

                S_LOAD, S_FETCH: begin
                    if (is_exception) begin
                        state           <= S_IDLE;
                        is_stall_to_slb <= 1'b0;
                    end else if (cnt == 3'd3) begin
                        if (state == S_LOAD) begin
                            data_to_slb      <= {mem_din, word_q};
                            is_finish_to_slb <= 1'b1;
                            is_instr_to_slb  <= 1'b1;
                            state            <= S_RESP;
                        end else begin
                            instr_to_if     <= {mem_din, word_q};
                            is_finish_to_if <= 1'b1;
                            is_stall_to_slb <= 1'b0;
                            state           <= S_IDLE;
                        end
                    end else begin
                        // mem_din carries the byte addressed in the previous cycle.
                        case (cnt[1:0])
                            2'd0:    word_q[7:0]   <= mem_din;
                            2'd1:    word_q[15:8]  <= mem_din;
                            default: word_q[23:16] <= mem_din;
                        endcase
                        cnt   <= cnt_nxt;
                        mem_a <= addr_q + AddrWidth'(cnt_nxt);
                    end
                end

                S_STORE: begin
                    // Exceptions are ignored here so a committed store never tears.
                    if (cnt_nxt == len_q) begin
                        mem_wr           <= 1'b0;
                        is_finish_to_slb <= 1'b1;
                        is_instr_to_slb  <= 1'b0;
                        is_stall_to_slb  <= 1'b0;
                        state            <= S_IDLE;
                    end else begin
                        cnt      <= cnt_nxt;
                        mem_a    <= addr_q + AddrWidth'(cnt_nxt);
                        mem_dout <= store_byte(data_q, cnt_nxt[1:0]);
                    end
                end

                S_IO_WAIT: begin
                    if (!io_buffer_full) begin
                        state    <= S_STORE;
                        cnt      <= '0;
                        mem_a    <= addr_q;
                        mem_wr   <= 1'b1;
                        mem_dout <= data_q[7:0];
                    end
                end

                S_RESP: begin
                    if (is_exception || is_receive_from_slb) begin
                        is_finish_to_slb <= 1'b0;
                        is_instr_to_slb  <= 1'b0;
                        is_stall_to_slb  <= 1'b0;
                        state            <= S_IDLE;
                    end
                end

                default: begin
                    state           <= S_IDLE;
                    mem_wr          <= 1'b0;
                    is_stall_to_slb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl_fc.sv
// Bench for mem_ctrl_fc: cycle-exact event scoreboard fed by a transaction-level
// model (byte memory + latency rules), checked by a negedge monitor.
module tb_mem_ctrl_fc;
    localparam logic [31:0] IO = 32'h30000;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_exception;
    logic [31:0] addr_from_slb;
    logic [31:0] data_from_slb;
    logic [2:0]  len_from_slb;
    logic        is_empty_from_slb;
    logic        is_store_from_slb;
    logic        is_receive_from_slb;
    logic [31:0] data_to_slb;
    logic        is_stall_to_slb;
    logic        is_finish_to_slb;
    logic        is_instr_to_slb;
    logic [31:0] addr_from_if;
    logic        is_req_from_if;
    logic [31:0] instr_to_if;
    logic        is_finish_to_if;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    mem_ctrl_fc #(.AddrWidth(32), .IoAddr(IO)) dut (
        .clk(clk), .rst(rst), .is_exception(is_exception),
        .addr_from_slb(addr_from_slb), .data_from_slb(data_from_slb),
        .len_from_slb(len_from_slb), .is_empty_from_slb(is_empty_from_slb),
        .is_store_from_slb(is_store_from_slb), .is_receive_from_slb(is_receive_from_slb),
        .data_to_slb(data_to_slb), .is_stall_to_slb(is_stall_to_slb),
        .is_finish_to_slb(is_finish_to_slb), .is_instr_to_slb(is_instr_to_slb),
        .addr_from_if(addr_from_if), .is_req_from_if(is_req_from_if),
        .instr_to_if(instr_to_if), .is_finish_to_if(is_finish_to_if),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // kind: 0 write, 1 slb finish rise, 2 slb finish fall, 3 fetch finish rise, 4 fetch finish fall
    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;
    ev_t exp_q[$];

    logic [7:0] ram [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction
    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_rd(a + 32'd3), ref_rd(a + 32'd2), ref_rd(a + 32'd1), ref_rd(a)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k; e.cyc = c; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic pre(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        ref_mem[a] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic observe(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: kind %0d a=%h d=%h at cycle %0d, none expected", k, a, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.a !== a || e.d !== d) begin
                n_fail++;
                $display("FAIL event: got kind %0d cycle %0d a=%h d=%h, expected kind %0d cycle %0d a=%h d=%h",
                         k, cyc, a, d, e.kind, e.cyc, e.a, e.d);
            end
        end
    endtask

    // RAM model and output monitor, both away from the active edge.
    initial begin : monitor
        logic p_fs;
        logic p_fi;
        p_fs = 1'b0;
        p_fi = 1'b0;
        mem_din = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_wr === 1'b1) ram[mem_a] = mem_dout;
            mem_din = ram_rd(mem_a);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL missing_event: kind %0d expected at cycle %0d, not seen by cycle %0d",
                         exp_q[0].kind, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (mem_wr === 1'b1) observe(0, mem_a, {24'h0, mem_dout});
            if (is_finish_to_slb && !p_fs)
                observe(1, {31'h0, is_instr_to_slb}, is_instr_to_slb ? data_to_slb : 32'h0);
            if (!is_finish_to_slb && p_fs) observe(2, 32'h0, 32'h0);
            if (is_finish_to_if && !p_fi) observe(3, 32'h0, instr_to_if);
            if (!is_finish_to_if && p_fi) observe(4, 32'h0, 32'h0);
            p_fs = is_finish_to_slb;
            p_fi = is_finish_to_if;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_to_slb"}, data_to_slb, 32'h0);
        chk({tag, "_stall"}, {31'h0, is_stall_to_slb}, 32'h0);
        chk({tag, "_finish_slb"}, {31'h0, is_finish_to_slb}, 32'h0);
        chk({tag, "_instr_slb"}, {31'h0, is_instr_to_slb}, 32'h0);
        chk({tag, "_instr_to_if"}, instr_to_if, 32'h0);
        chk({tag, "_finish_if"}, {31'h0, is_finish_to_if}, 32'h0);
        chk({tag, "_mem_dout"}, {24'h0, mem_dout}, 32'h0);
        chk({tag, "_mem_a"}, mem_a, 32'h0);
        chk({tag, "_mem_wr"}, {31'h0, mem_wr}, 32'h0);
    endtask

    // exc_k: 0 = none, else the edge (relative to accept) that samples is_exception.
    task automatic do_load(input logic [31:0] a, input int rdelay, input int exc_k);
        int e0;
        is_empty_from_slb = 1'b0; is_store_from_slb = 1'b0; addr_from_slb = a;
        data_from_slb = $urandom; len_from_slb = 3'($urandom_range(0, 7));
        e0 = cyc + 1;
        tick();
        is_empty_from_slb = 1'b1;
        chk("load_stall_busy", {31'h0, is_stall_to_slb}, 32'h1);
        if (exc_k == 0) begin
            push(1, e0 + 4, 32'h1, ref_word(a));
            push(2, e0 + 5 + rdelay, 32'h0, 32'h0);
            while (cyc < e0 + 5 + rdelay) begin
                is_receive_from_slb = (cyc >= e0 + 4 + rdelay);
                tick();
            end
            is_receive_from_slb = 1'b0;
        end else begin
            if (exc_k >= 5) begin
                push(1, e0 + 4, 32'h1, ref_word(a));
                push(2, e0 + exc_k, 32'h0, 32'h0);
            end
            while (cyc < e0 + exc_k) begin
                is_exception = (cyc + 1 >= e0 + exc_k);
                tick();
            end
            is_exception = 1'b0;
        end
        chk("load_stall_free", {31'h0, is_stall_to_slb}, 32'h0);
    endtask

    task automatic do_fetch(input logic [31:0] a, input int exc_k);
        int e0;
        is_req_from_if = 1'b1; addr_from_if = a;
        e0 = cyc + 1;
        tick();
        chk("fetch_stall_busy", {31'h0, is_stall_to_slb}, 32'h1);
        if (exc_k == 0) begin
            push(3, e0 + 4, 32'h0, ref_word(a));
            push(4, e0 + 5, 32'h0, 32'h0);
            while (cyc < e0 + 5) begin
                if (cyc >= e0 + 4) is_req_from_if = 1'b0;
                tick();
            end
        end else begin
            while (cyc < e0 + exc_k) begin
                is_exception = (cyc + 1 >= e0 + exc_k);
                tick();
            end
            is_exception = 1'b0;
            is_req_from_if = 1'b0;
        end
        chk("fetch_stall_free", {31'h0, is_stall_to_slb}, 32'h0);
    endtask

    // fc: cycles io_buffer_full is held high from acceptance on.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] len,
                            input int fc, input bit exc);
        int e0, w, n;
        logic [31:0] ak;
        n = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
        is_empty_from_slb = 1'b0; is_store_from_slb = 1'b1;
        addr_from_slb = a; data_from_slb = d; len_from_slb = len;
        io_buffer_full = (fc > 0);
        e0 = cyc + 1;
        w = (a == IO && fc > 0) ? e0 + fc : e0;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            push(0, w + k, ak, {24'h0, d[8*k +: 8]});
            ref_mem[ak] = d[8*k +: 8];
        end
        push(1, w + n, 32'h0, 32'h0);
        push(2, w + n + 1, 32'h0, 32'h0);
        tick();
        is_empty_from_slb = 1'b1;
        chk("store_stall_busy", {31'h0, is_stall_to_slb}, 32'h1);
        while (cyc < w + n + 1) begin
            if (cyc + 1 >= e0 + fc) io_buffer_full = 1'b0;
            if (exc) is_exception = (cyc >= e0 && cyc < e0 + 2);
            tick();
        end
        io_buffer_full = 1'b0;
        is_exception = 1'b0;
        chk("store_stall_free", {31'h0, is_stall_to_slb}, 32'h0);
    endtask

    task automatic do_load_fetch(input logic [31:0] la, input logic [31:0] fa, input int rdelay);
        int e0, r;
        is_empty_from_slb = 1'b0; is_store_from_slb = 1'b0; addr_from_slb = la;
        is_req_from_if = 1'b1; addr_from_if = fa;
        e0 = cyc + 1;
        r = e0 + 5 + rdelay;
        push(1, e0 + 4, 32'h1, ref_word(la));
        push(2, r, 32'h0, 32'h0);
        push(3, r + 5, 32'h0, ref_word(fa));
        push(4, r + 6, 32'h0, 32'h0);
        tick();
        is_empty_from_slb = 1'b1;
        while (cyc < r + 6) begin
            is_receive_from_slb = (cyc >= e0 + 4 + rdelay && cyc < r);
            if (cyc >= r + 5) is_req_from_if = 1'b0;
            tick();
        end
        is_receive_from_slb = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : driver
        int e0;
        logic [31:0] a;
        rst = 1'b1;
        is_exception = 1'b0; addr_from_slb = '0; data_from_slb = '0; len_from_slb = '0;
        is_empty_from_slb = 1'b1; is_store_from_slb = 1'b0; is_receive_from_slb = 1'b0;
        addr_from_if = '0; is_req_from_if = 1'b0; io_buffer_full = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        pre(32'h100, 8'h11); pre(32'h101, 8'h22); pre(32'h102, 8'h33); pre(32'h103, 8'h44);
        do_load(32'h100, 2, 0);

        pre(32'h202, 8'h77);
        do_store(32'h200, 32'hAABBCCDD, 3'd2, 0, 1'b0);
        chk("store_len2_untouched", {24'h0, ram_rd(32'h202)}, 32'h77);

        pre(32'h0, 8'hEF); pre(32'h1, 8'hBE); pre(32'h2, 8'hAD); pre(32'h3, 8'hDE);
        do_load_fetch(32'h100, 32'h0, 1);

        do_store(IO, 32'h12345678, 3'd1, 5, 1'b0);

        do_load(32'h100, 0, 3);
        do_store(32'h300, 32'hCAFEF00D, 3'd4, 0, 1'b1);
        do_fetch(32'h0, 2);
        do_load(32'h100, 5, 6);

        // Exception in IDLE blocks acceptance for that edge.
        is_exception = 1'b1;
        is_empty_from_slb = 1'b0; is_store_from_slb = 1'b0; addr_from_slb = 32'h100;
        tick();
        chk("idle_exc_no_accept", {31'h0, is_stall_to_slb}, 32'h0);
        is_exception = 1'b0;
        do_load(32'h100, 0, 0);

        // Reset in the middle of a 4-byte store.
        is_empty_from_slb = 1'b0; is_store_from_slb = 1'b1;
        addr_from_slb = 32'h400; data_from_slb = 32'h0BADBEEF; len_from_slb = 3'd4;
        e0 = cyc + 1;
        push(0, e0, 32'h400, 32'hEF);
        push(0, e0 + 1, 32'h401, 32'hBE);
        ref_mem[32'h400] = 8'hEF;
        ref_mem[32'h401] = 8'hBE;
        tick();
        is_empty_from_slb = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        tick();
        rst = 1'b0;
        tick();
        do_load(32'h400, 1, 0);

        // Illegal length and address wrap.
        do_store(32'hFFFFFFFE, 32'h55667788, 3'd3, 0, 1'b0);
        do_load(32'hFFFFFFFF, 0, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
                1: a = IO;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: do_load(a, $urandom_range(0, 3), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0);
                1: do_store(a, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
                2: do_fetch(a, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0);
                default: do_load_fetch(a, $urandom, $urandom_range(0, 2));
            endcase
        end

        repeat (4) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
